pc_gen: RTL and testbench

Parametrised program-counter generator for the rooth core front end, replacing the fixed-width PC register. It holds the current fetch address, advances it only on a fetch valid/ready handshake, and supports 16-bit (compressed) steps. It keeps execute-stage redirects that arrive during a pipeline stall, and predicts return targets from a small circular return-address stack (RAS). It sits between the flow-control unit, the predecoder and the instruction-fetch interface.

---
 rtl/pc_gen_if.sv | 33 +++
 rtl/pc_gen.sv | 164 ++++++++++++++++
 tb/tb_pc_gen.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Fetch-side bundle of the program-counter generator: flow control, redirect,
// predecoder hints and the fetch request/response handshake.
interface pc_gen_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic [1:0]      flow_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            half_step_i;
  logic            call_i;
  logic            ret_i;
  logic            fetch_ready_i;
  logic            fetch_valid_o;
  logic [XLEN-1:0] pc_o;
  logic            ras_pred_o;
  logic [CW-1:0]   ras_count_o;

  // master is the PC generator, which issues fetch requests
  modport master (
    input  flow_i, redirect_i, redirect_pc_i, half_step_i, call_i, ret_i,
           fetch_ready_i,
    output fetch_valid_o, pc_o, ras_pred_o, ras_count_o
  );

  modport slave (
    output flow_i, redirect_i, redirect_pc_i, half_step_i, call_i, ret_i,
           fetch_ready_i,
    input  fetch_valid_o, pc_o, ras_pred_o, ras_count_o
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: handshake-gated PC advance, compressed steps,
// stall-safe redirect capture and a circular return-address stack.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              C_EXT     = 1,
  parameter int              RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     jtag_reset_i,
  pc_gen_if.master bus
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;
  localparam int PW = $clog2(RAS_DEPTH);

  localparam logic [1:0] FLOW_WORK = 2'b00;
  localparam logic [1:0] FLOW_STOP = 2'b01;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_t;

  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] t);
    logic [XLEN-1:0] mask;
    mask = (C_EXT != 0) ? XLEN'(1) : XLEN'(3);
    return t & ~mask;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CW'(RAS_DEPTH)) ? c : c + CW'(1);
  endfunction

  // Registered state
  state_t          state_p1, state_d;
  logic [XLEN-1:0] pc_p1, pc_d;
  logic            ras_pred_p1, pred_d;
  logic [XLEN-1:0] pend_pc_p1, pend_pc_d;
  logic [CW-1:0]   ras_count_p1;
  logic [PW-1:0]   ras_wp_p1;
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];

  logic            hard_rst;
  logic            refresh;
  logic            work;
  logic            stop;
  logic            pend_vld;
  logic            fire;
  logic [XLEN-1:0] step;
  logic [XLEN-1:0] seq_pc;
  logic [PW-1:0]   ras_top_idx;
  logic [XLEN-1:0] ras_top;
  logic            ras_push;
  logic            ras_pop;
  logic            ras_clear;
  logic [PW-1:0]   ras_wr_idx;

  assign hard_rst    = !rst_n || jtag_reset_i;
  assign refresh     = bus.flow_i[1];
  assign work        = (bus.flow_i == FLOW_WORK);
  assign stop        = (bus.flow_i == FLOW_STOP);
  assign pend_vld    = (state_p1 == S_PEND);

  assign bus.fetch_valid_o = work && !bus.redirect_i && !pend_vld;
  assign fire        = bus.fetch_valid_o && bus.fetch_ready_i;

  assign step        = ((C_EXT != 0) && bus.half_step_i) ? XLEN'(2) : XLEN'(4);
  assign seq_pc      = pc_p1 + step;
  assign ras_top_idx = ras_wp_p1 - PW'(1);
  assign ras_top     = ras_mem[ras_top_idx];
  // A simultaneous pop+push reuses the popped slot so depth stays unchanged
  assign ras_wr_idx  = ras_pop ? ras_top_idx : ras_wp_p1;

  always_comb begin
    state_d   = state_p1;
    pc_d      = pc_p1;
    pred_d    = ras_pred_p1;
    pend_pc_d = pend_pc_p1;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_clear = 1'b0;
    if (refresh) begin
      pc_d      = RESET_VEC;
      pred_d    = 1'b0;
      state_d   = S_IDLE;
      ras_clear = 1'b1;
    end else if (bus.redirect_i) begin
      if (work) begin
        pc_d    = align_target(bus.redirect_pc_i);
        pred_d  = 1'b0;
        state_d = S_IDLE;
      end else begin
        pend_pc_d = align_target(bus.redirect_pc_i);
        state_d   = S_PEND;
      end
    end else if (pend_vld && work) begin
      pc_d    = pend_pc_p1;
      pred_d  = 1'b0;
      state_d = S_IDLE;
    end else if (stop) begin
      state_d = state_p1;
    end else if (fire) begin
      pc_d     = seq_pc;
      pred_d   = 1'b0;
      ras_push = bus.call_i;
      if (bus.ret_i && (ras_count_p1 != '0)) begin
        pc_d    = ras_top;
        pred_d  = 1'b1;
        ras_pop = 1'b1;
      end
    end
  end

  // Stage p1: PC, prediction flag and pending-redirect state
  always_ff @(posedge clk) begin
    if (hard_rst) begin
      state_p1    <= S_IDLE;
      pc_p1       <= RESET_VEC;
      ras_pred_p1 <= 1'b0;
    end else begin
      state_p1    <= state_d;
      pc_p1       <= pc_d;
      ras_pred_p1 <= pred_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_pc_p1 <= pend_pc_d;
  end

  always_ff @(posedge clk) begin
    if (hard_rst || ras_clear) begin
      ras_wp_p1    <= '0;
      ras_count_p1 <= '0;
    end else begin
      unique case ({ras_push, ras_pop})
        2'b10: begin
          ras_wp_p1    <= ras_wp_p1 + PW'(1);
          ras_count_p1 <= sat_inc(ras_count_p1);
        end
        2'b01: begin
          ras_wp_p1    <= ras_wp_p1 - PW'(1);
          ras_count_p1 <= ras_count_p1 - CW'(1);
        end
        default: begin
          ras_wp_p1    <= ras_wp_p1;
          ras_count_p1 <= ras_count_p1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ras_push) begin
      ras_mem[ras_wr_idx] <= seq_pc;
    end
  end

  assign bus.pc_o        = pc_p1;
  assign bus.ras_pred_o  = ras_pred_p1;
  assign bus.ras_count_o = ras_count_p1;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a C_EXT=1 instance and a C_EXT=0 twin fed the
// same stimulus, checked against hand-computed PCs.
module tb_pc_gen;
  logic clk = 1'b0;
  logic rst_n;
  logic jtag_reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(32), .RAS_DEPTH(4)) bus0 ();
  pc_gen_if #(.XLEN(32), .RAS_DEPTH(4)) bus1 ();

  pc_gen #(.XLEN(32), .RESET_VEC(32'h80), .C_EXT(1), .RAS_DEPTH(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .jtag_reset_i(jtag_reset), .bus(bus0.master));
  pc_gen #(.XLEN(32), .RESET_VEC(32'h80), .C_EXT(0), .RAS_DEPTH(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .jtag_reset_i(jtag_reset), .bus(bus1.master));

  assign bus1.flow_i        = bus0.flow_i;
  assign bus1.redirect_i    = bus0.redirect_i;
  assign bus1.redirect_pc_i = bus0.redirect_pc_i;
  assign bus1.half_step_i   = bus0.half_step_i;
  assign bus1.call_i        = bus0.call_i;
  assign bus1.ret_i         = bus0.ret_i;
  assign bus1.fetch_ready_i = bus0.fetch_ready_i;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic redirect_to(input logic [31:0] a);
    bus0.redirect_i    = 1'b1;
    bus0.redirect_pc_i = a;
    tick();
    bus0.redirect_i    = 1'b0;
  endtask

  initial begin
    logic [31:0] pops [4];
    pops = '{32'h54, 32'h44, 32'h34, 32'h24};
    rst_n              = 1'b0;
    jtag_reset         = 1'b0;
    bus0.flow_i        = 2'b01;
    bus0.redirect_i    = 1'b0;
    bus0.redirect_pc_i = '0;
    bus0.half_step_i   = 1'b0;
    bus0.call_i        = 1'b0;
    bus0.ret_i         = 1'b0;
    bus0.fetch_ready_i = 1'b0;
    tick();
    tick();
    chk("rst_pc", bus0.pc_o, 32'h80);
    chk("rst_pred", bus0.ras_pred_o, 1'b0);
    chk("rst_count", bus0.ras_count_o, 3'd0);
    chk("rst_pc_c0", bus1.pc_o, 32'h80);

    // Sequential fetch with a one-cycle ready drop
    rst_n = 1'b1;
    bus0.flow_i = 2'b00;
    bus0.fetch_ready_i = 1'b1;
    #1;
    chk("fv_work", bus0.fetch_valid_o, 1'b1);
    tick(); chk("seq_84", bus0.pc_o, 32'h84);
    tick(); chk("seq_88", bus0.pc_o, 32'h88);
    bus0.fetch_ready_i = 1'b0;
    tick(); chk("stall_hold", bus0.pc_o, 32'h88);
    bus0.fetch_ready_i = 1'b1;
    tick(); chk("seq_8c", bus0.pc_o, 32'h8c);

    // Compressed step and redirect alignment on both variants
    bus0.redirect_i = 1'b1;
    bus0.redirect_pc_i = 32'h100;
    #1;
    chk("fv_redirect", bus0.fetch_valid_o, 1'b0);
    tick();
    bus0.redirect_i = 1'b0;
    chk("redir_100", bus0.pc_o, 32'h100);
    bus0.half_step_i = 1'b1;
    tick();
    bus0.half_step_i = 1'b0;
    chk("half_step_c1", bus0.pc_o, 32'h102);
    chk("half_step_c0", bus1.pc_o, 32'h104);
    redirect_to(32'h203);
    chk("align_c1", bus0.pc_o, 32'h202);
    chk("align_c0", bus1.pc_o, 32'h200);

    // Redirects captured during STOP; the newest wins
    bus0.flow_i = 2'b01;
    bus0.redirect_i = 1'b1;
    bus0.redirect_pc_i = 32'h400;
    tick(); chk("stop_hold1", bus0.pc_o, 32'h202);
    bus0.redirect_pc_i = 32'h500;
    tick(); chk("stop_hold2", bus0.pc_o, 32'h202);
    bus0.redirect_i = 1'b0;
    tick(); chk("stop_hold3", bus0.pc_o, 32'h202);
    bus0.flow_i = 2'b00;
    #1;
    chk("fv_pend", bus0.fetch_valid_o, 1'b0);
    tick(); chk("pend_apply", bus0.pc_o, 32'h500);
    chk("fv_after_pend", bus0.fetch_valid_o, 1'b1);
    tick(); chk("pend_seq", bus0.pc_o, 32'h504);

    // REFRESH then RAS overflow and drain
    bus0.flow_i = 2'b10;
    tick(); chk("refresh_pc", bus0.pc_o, 32'h80);
    bus0.flow_i = 2'b00;
    for (int i = 1; i <= 5; i++) begin
      redirect_to(32'(i * 16));
      bus0.call_i = 1'b1;
      tick();
      bus0.call_i = 1'b0;
    end
    chk("ras_full_count", bus0.ras_count_o, 3'd4);
    chk("ras_call_pc", bus0.pc_o, 32'h54);
    bus0.ret_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ret_pc", bus0.pc_o, 64'(pops[i]));
      chk("ret_pred", bus0.ras_pred_o, 1'b1);
      chk("ret_count", bus0.ras_count_o, 64'(3 - i));
    end
    tick();
    chk("ret_empty_pc", bus0.pc_o, 32'h28);
    chk("ret_empty_pred", bus0.ras_pred_o, 1'b0);
    bus0.ret_i = 1'b0;

    // Simultaneous call and return
    redirect_to(32'h30);
    bus0.call_i = 1'b1;
    tick();
    bus0.call_i = 1'b0;
    redirect_to(32'h60);
    bus0.call_i = 1'b1;
    bus0.ret_i = 1'b1;
    tick();
    bus0.call_i = 1'b0;
    chk("callret_pc", bus0.pc_o, 32'h34);
    chk("callret_count", bus0.ras_count_o, 3'd1);
    tick();
    bus0.ret_i = 1'b0;
    chk("callret_top", bus0.pc_o, 32'h64);
    chk("callret_drain", bus0.ras_count_o, 3'd0);

    // Address wrap
    redirect_to(32'hFFFF_FFFC);
    tick(); chk("wrap", bus0.pc_o, 32'h0);

    // JTAG reset during a stall
    bus0.call_i = 1'b1;
    tick();
    bus0.call_i = 1'b0;
    chk("pre_jtag_count", bus0.ras_count_o, 3'd1);
    bus0.fetch_ready_i = 1'b0;
    tick(); chk("pre_jtag_hold", bus0.pc_o, 32'h4);
    jtag_reset = 1'b1;
    tick();
    jtag_reset = 1'b0;
    chk("jtag_pc", bus0.pc_o, 32'h80);
    chk("jtag_count", bus0.ras_count_o, 3'd0);

    // Reserved flow code mid-pending behaves as REFRESH
    bus0.fetch_ready_i = 1'b1;
    bus0.flow_i = 2'b01;
    bus0.redirect_i = 1'b1;
    bus0.redirect_pc_i = 32'h700;
    tick();
    bus0.redirect_i = 1'b0;
    bus0.flow_i = 2'b11;
    tick(); chk("flow11_pc", bus0.pc_o, 32'h80);
    bus0.flow_i = 2'b00;
    #1;
    chk("flow11_nopend", bus0.fetch_valid_o, 1'b1);
    tick(); chk("flow11_seq", bus0.pc_o, 32'h84);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
